// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit slice.
package adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/nibble_adder_cout.sv
// 4-bit ripple-carry slice built from one-bit full-adder cells; exposes the carry out of bit 3.
module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (c_i & (x_i ^ y_i));
endmodule

module nibble_adder_cout
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] in1,
  input  logic [NIBBLE_W-1:0] in2,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] out,
  output logic                carry_out
);
  logic [NIBBLE_W:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    full_adder u_fa (
      .x_i (in1[i]),
      .y_i (in2[i]),
      .c_i (c[i]),
      .s_o (out[i]),
      .c_o (c[i+1])
    );
  end

  assign carry_out = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit slice, LSB nibble first.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  state_e                state_q;
  logic [WIDTH-1:0]      a_q, b_q, sum_q, sum_d;
  logic                  carry_q, cout_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NIBBLE_W-1:0]   slice_sum;
  logic                  slice_co;

  nibble_adder_cout u_slice (
    .in1       (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .in2       (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .carry_in  (carry_q),
    .out       (slice_sum),
    .carry_out (slice_co)
  );

  // Merge the current slice result into its nibble lane; other lanes keep their value.
  always_comb begin
    sum_d = sum_q;
    sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_co;
          // Top nibble: exit before idx could run past the last lane.
          if (idx_q == IDX_W'(NIBBLES - 1)) begin
            cout_q  <= slice_co;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
